uart_rx_sampler: RTL and testbench

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

---
 rtl/uart_rx_sampler.sv | 134 +++++++++++++
 tb/tb_uart_rx_sampler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver with 16x oversampling, 2-of-3 majority voting per bit,
// glitch rejection on the start bit and break handling after a framing error.
module uart_rx_sampler #(
  parameter int TICK_DIV = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RX,
  output logic       RX_DONE,
  output logic [7:0] RX_DATA,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state, state_next;
  logic          rx_meta, rx_s;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    samp_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    votes;
  logic [7:0]    shreg;
  logic          start_det, stop_eval, stop_maj, data_maj;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign tick     = (tick_cnt == TICK_LAST);
  // STOP decides on the sample-9 tick itself, so the third vote is the live rx_s.
  assign stop_maj = maj3(votes[0], votes[1], rx_s);
  assign data_maj = maj3(votes[0], votes[1], votes[2]);

  // Synchronizer idles high so reset never looks like a start edge.
  // NOTE: clocked blocks use non-blocking (<=) so every flop updates from pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                 tick_cnt <= '0;
    else if (start_det || tick) tick_cnt <= '0;
    else                        tick_cnt <= tick_cnt + 1'b1;
  end

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic. START validates the start bit at its middle (sample 7)
  // and hands over to DATA at its end, so DATA samples 7..9 sit mid-bit.
  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!rx_s) state_next = S_START;
      S_START: begin
        if (tick && samp_cnt == 4'd7 && rx_s) state_next = S_IDLE;
        else if (tick && samp_cnt == 4'd15)   state_next = S_DATA;
      end
      S_DATA:  if (tick && samp_cnt == 4'd15 && bit_idx == 3'd7) state_next = S_STOP;
      S_STOP:  if (stop_eval) state_next = stop_maj ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output / decode logic
  always_comb begin
    BUSY      = (state != S_IDLE);
    start_det = (state == S_IDLE) && !rx_s;
    stop_eval = (state == S_STOP) && tick && (samp_cnt == 4'd9);
  end

  // Sample counter wraps 15->0, which doubles as the clear on START->DATA.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      samp_cnt <= '0;
      bit_idx  <= '0;
      votes    <= '0;
      shreg    <= '0;
    end else if (start_det) begin
      samp_cnt <= '0;
      bit_idx  <= '0;
    end else if (tick) begin
      if (state == S_START || state == S_DATA || state == S_STOP)
        samp_cnt <= samp_cnt + 4'd1;
      if (state == S_DATA || state == S_STOP) begin
        case (samp_cnt)
          4'd7:    votes[0] <= rx_s;
          4'd8:    votes[1] <= rx_s;
          4'd9:    votes[2] <= rx_s;
          default: ;
        endcase
      end
      if (state == S_DATA && samp_cnt == 4'd15) begin
        shreg   <= {data_maj, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      RX_DONE   <= 1'b0;
      FRAME_ERR <= 1'b0;
      RX_DATA   <= 8'h00;
    end else begin
      RX_DONE   <= stop_eval && stop_maj;
      FRAME_ERR <= stop_eval && !stop_maj;
      if (stop_eval && stop_maj) RX_DATA <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: directed frames against an event-queue model of
// received bytes / framing errors, checked every cycle on the falling edge.
module tb_uart_rx_sampler;

  localparam int  TICK_DIV = 8;
  localparam real BIT_CLK  = 16.0 * TICK_DIV;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       RX = 1'b1;
  logic       RX_DONE, FRAME_ERR, BUSY;
  logic [7:0] RX_DATA;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } event_t;

  event_t     exp_q[$];
  logic [7:0] model_data = 8'h00;
  int         done_cycles[$];

  uart_rx_sampler #(.TICK_DIV(TICK_DIV)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .RX       (RX),
    .RX_DONE  (RX_DONE),
    .RX_DATA  (RX_DATA),
    .FRAME_ERR(FRAME_ERR),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic event_t byte_ev(input logic [7:0] d);
    event_t e;
    e.is_err = 1'b0;
    e.data   = d;
    return e;
  endfunction

  // Drive one frame cycle by cycle: start, 8 data bits LSB first, stop bit(s).
  // spike inverts RX for one clock 72 cycles into each data bit (sample 8).
  task automatic send_frame(input logic [7:0] d, input real per, input int stop_bits,
                            input bit stop_low, input bit spike);
    int   total, idx, off;
    logic v;
    total = $rtoi(per * real'(9 + stop_bits));
    for (int c = 0; c < total; c++) begin
      idx = $rtoi(real'(c) / per);
      if (idx == 0)      v = 1'b0;
      else if (idx <= 8) v = d[idx-1];
      else               v = ~stop_low;
      off = c - $rtoi(real'(idx) * per);
      if (spike && idx >= 1 && idx <= 8 && off == 9 * TICK_DIV) v = ~v;
      RX = v;
      step(1);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Compare process: every pulse must match the next expected event, RX_DATA
  // must always equal the last good byte, pulses exclusive and one cycle wide.
  initial begin
    event_t ev;
    bit     prev_done = 1'b0;
    bit     prev_err  = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESET) model_data = 8'h00;
      if (RX_DONE || FRAME_ERR) begin
        check("pulse_exclusive", {31'd0, RX_DONE & FRAME_ERR}, 0);
        check("pulse_width", {31'd0, (RX_DONE & prev_done) | (FRAME_ERR & prev_err)}, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse actual done=%0b err=%0b data=%0h required no pulse (cycle %0d)",
                   RX_DONE, FRAME_ERR, RX_DATA, cyc);
        end else begin
          ev = exp_q.pop_front();
          check("pulse_kind_err", {31'd0, FRAME_ERR}, {31'd0, ev.is_err});
          if (RX_DONE && !ev.is_err) model_data = ev.data;
        end
      end
      if (RX_DONE) done_cycles.push_back(cyc);
      check("rx_data_model", {24'd0, RX_DATA}, {24'd0, model_data});
      prev_done = RX_DONE;
      prev_err  = FRAME_ERR;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, lat;
    int exp_lat;
    event_t e;
    exp_lat = 2 + (16 * 9 + 9 + 1) * TICK_DIV;

    // Reset state, before any clock edge
    #2;
    check("reset_rx_done", {31'd0, RX_DONE}, 0);
    check("reset_frame_err", {31'd0, FRAME_ERR}, 0);
    check("reset_busy", {31'd0, BUSY}, 0);
    check("reset_rx_data", {24'd0, RX_DATA}, 32'h00);
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;
    step(4);
    check("post_release_busy", {31'd0, BUSY}, 0);

    // Back-to-back 0x55, 0xA3 with start-to-done latency
    exp_q.push_back(byte_ev(8'h55));
    exp_q.push_back(byte_ev(8'hA3));
    t0 = cyc;
    send_frame(8'h55, BIT_CLK, 1, 1'b0, 1'b0);
    send_frame(8'hA3, BIT_CLK, 1, 1'b0, 1'b0);
    drain("b2b_drain", 400);
    check("b2b_done_count", done_cycles.size(), 2);
    check("b2b_last_byte", {24'd0, RX_DATA}, 32'hA3);
    if (done_cycles.size() > 0) begin
      lat = done_cycles[0] - t0;
      check("rx_done_latency",
            (lat >= exp_lat - TICK_DIV && lat <= exp_lat + TICK_DIV) ? exp_lat : lat, exp_lat);
    end
    step(50);

    // 40-clock glitch on idle line
    RX = 1'b0;
    step(20);
    check("glitch_busy_in_start", {31'd0, BUSY}, 1);
    step(20);
    RX = 1'b1;
    step(100);
    check("glitch_back_idle", {31'd0, BUSY}, 0);
    check("glitch_data_kept", {24'd0, RX_DATA}, 32'hA3);
    check("glitch_no_pulse", done_cycles.size(), 2);

    // Stop bit held low for 3 bit periods -> framing error, BREAK until high
    e.is_err = 1'b1;
    e.data   = 8'h00;
    exp_q.push_back(e);
    send_frame(8'h3C, BIT_CLK, 1, 1'b1, 1'b0);
    step(2 * 16 * TICK_DIV);
    check("break_err_seen", exp_q.size(), 0);
    check("break_busy_held_low", {31'd0, BUSY}, 1);
    check("break_data_kept", {24'd0, RX_DATA}, 32'hA3);
    RX = 1'b1;
    step(4);
    check("break_exit_idle", {31'd0, BUSY}, 0);
    step(50);
    exp_q.push_back(byte_ev(8'h81));
    send_frame(8'h81, BIT_CLK, 1, 1'b0, 1'b0);
    drain("after_break_drain", 400);
    check("after_break_byte", {24'd0, RX_DATA}, 32'h81);
    step(50);

    // Majority voting against a one-clock spike at sample 8 of every data bit
    exp_q.push_back(byte_ev(8'hF0));
    send_frame(8'hF0, BIT_CLK, 1, 1'b0, 1'b1);
    drain("spike_drain", 400);
    check("spike_byte", {24'd0, RX_DATA}, 32'hF0);
    step(50);

    // Reset for 3 clocks during data bit 4; rest of 0xF5 is all ones
    fork
      send_frame(8'hF5, BIT_CLK, 1, 1'b0, 1'b0);
      begin
        step(650);
        RESET = 1'b0;
        #1;
        check("midreset_rx_done", {31'd0, RX_DONE}, 0);
        check("midreset_frame_err", {31'd0, FRAME_ERR}, 0);
        check("midreset_busy", {31'd0, BUSY}, 0);
        check("midreset_rx_data", {24'd0, RX_DATA}, 32'h00);
        step(3);
        RESET = 1'b1;
      end
    join
    step(300);
    check("midreset_idle", {31'd0, BUSY}, 0);
    check("midreset_no_pulse", done_cycles.size(), 4);
    exp_q.push_back(byte_ev(8'h12));
    send_frame(8'h12, BIT_CLK, 1, 1'b0, 1'b0);
    drain("midreset_next_drain", 400);
    check("midreset_next_byte", {24'd0, RX_DATA}, 32'h12);
    step(50);

    // 0x00 at +3% and -3% bit rate
    exp_q.push_back(byte_ev(8'h00));
    send_frame(8'h00, BIT_CLK / 1.03, 1, 1'b0, 1'b0);
    drain("fast_drain", 400);
    check("fast_done_count", done_cycles.size(), 6);
    check("fast_byte", {24'd0, RX_DATA}, 32'h00);
    step(50);
    exp_q.push_back(byte_ev(8'h00));
    send_frame(8'h00, BIT_CLK / 0.97, 1, 1'b0, 1'b0);
    drain("slow_drain", 400);
    check("slow_done_count", done_cycles.size(), 7);
    check("slow_byte", {24'd0, RX_DATA}, 32'h00);
    step(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
